fractran_sequencer: RTL

Program sequencer for the Fractran evaluation core. Holds a loadable program of encoded fractions, presents them one at a time to the core, and tracks the Fractran program counter. Resets to the first fraction whenever the core applies one and halts when a full pass applies none. Sits between the top-level pin interface and the Fractran datapath, replacing host-driven fraction streaming.

---
 rtl/fractran_pkg.sv | 23 ++
 rtl/fractran_prog_mem.sv | 30 +++
 rtl/fractran_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fractran_pkg.sv
// Shared types and constants for the Fractran sequencer and evaluation core.
// Optional feature macro: FRACTRAN_STEP_LIMIT_EN (halt once MAX_STEPS fractions applied).
package fractran_pkg;

    localparam int unsigned DefProgDepth = 16;
    localparam int unsigned DefFracW     = 8;
    localparam int unsigned DefCntW      = 16;

    // Encoded fraction layout: numerator in the high nibble, denominator in the low nibble.
    localparam int unsigned FracNumMsb = 7;
    localparam int unsigned FracNumLsb = 4;
    localparam int unsigned FracDenMsb = 3;
    localparam int unsigned FracDenLsb = 0;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StPresent,
        StHalted
    } seq_state_e;

endpackage

// File: rtl/fractran_prog_mem.sv
// Program store: one write port, one synchronous read port. Contents are not reset.
module fractran_prog_mem #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Write port and registered read port; read data holds while re_i is low.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fractran_sequencer.sv
// Fractran program sequencer: loads a program of encoded fractions, presents them to the
// core one at a time and tracks the program counter and applied-step count.
// Optional feature macro: FRACTRAN_STEP_LIMIT_EN (halt with limit_hit once MAX_STEPS applied).
module fractran_sequencer
    import fractran_pkg::*;
#(
    parameter int unsigned     PROG_DEPTH = DefProgDepth,
    parameter int unsigned     FRAC_W     = DefFracW,
    parameter int unsigned     CNT_W      = DefCntW,
    parameter logic [CNT_W-1:0] MAX_STEPS = {CNT_W{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    input  logic [FRAC_W-1:0]             load_data,
    input  logic                          load_last,
    output logic                          load_ready,
    input  logic                          start,
    output logic [FRAC_W-1:0]             fraction,
    output logic                          frac_valid,
    input  logic                          core_ack,
    input  logic                          core_hit,
    output logic [$clog2(PROG_DEPTH)-1:0] pc,
    output logic [$clog2(PROG_DEPTH):0]   prog_len,
    output logic [CNT_W-1:0]              step_count,
    output logic                          busy,
    output logic                          halt,
    output logic                          limit_hit
);

    localparam int unsigned AW = $clog2(PROG_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LenFull = LW'(PROG_DEPTH);

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [LW-1:0]     len_q, len_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic              limit_q, limit_d;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic              mem_re;
    logic [FRAC_W-1:0] mem_rdata;

    fractran_prog_mem #(
        .Depth (PROG_DEPTH),
        .Width (FRAC_W)
    ) u_prog_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (load_data),
        .re_i    (mem_re),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    // State and counter registers; prog_len is cleared so a reset forces a reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            step_q  <= '0;
            limit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            step_q  <= step_d;
            limit_q <= limit_d;
        end
    end

    // Next-state, memory control and handshake outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        step_d     = step_q;
        limit_d    = limit_q;
        mem_we     = 1'b0;
        mem_waddr  = len_q[AW-1:0];
        mem_re     = 1'b0;
        load_ready = 1'b0;
        frac_valid = 1'b0;
        busy       = 1'b0;
        case (state_q)
            StIdle, StHalted: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    // A fresh load always restarts at index 0; a simultaneous start is dropped.
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    len_d     = LW'(1);
                    limit_d   = 1'b0;
                    state_d   = load_last ? StIdle : StLoad;
                end else if (start) begin
                    pc_d    = '0;
                    step_d  = '0;
                    limit_d = 1'b0;
                    state_d = (len_q != '0) ? StFetch : StHalted;
                end
            end
            StLoad: begin
                busy       = 1'b1;
                load_ready = (len_q != LenFull);
                if (load_valid) begin
                    if (len_q != LenFull) begin
                        mem_we = 1'b1;
                        len_d  = len_q + LW'(1);
                    end
                    if (load_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StFetch: begin
                busy    = 1'b1;
                mem_re  = 1'b1;
                state_d = StPresent;
            end
            StPresent: begin
                busy       = 1'b1;
                frac_valid = 1'b1;
                if (core_ack) begin
                    if (core_hit) begin
                        pc_d    = '0;
                        state_d = StFetch;
                        if (step_q != {CNT_W{1'b1}}) begin
                            step_d = step_q + CNT_W'(1);
                        end
`ifdef FRACTRAN_STEP_LIMIT_EN
                        if (step_d == MAX_STEPS) begin
                            state_d = StHalted;
                            limit_d = 1'b1;
                        end
`endif
                    end else if ({1'b0, pc_q} == len_q - LW'(1)) begin
                        state_d = StHalted;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data only reaches the core while a fraction is being presented.
    assign fraction   = (state_q == StPresent) ? mem_rdata : '0;
    assign pc         = pc_q;
    assign prog_len   = len_q;
    assign step_count = step_q;
    assign halt       = (state_q == StHalted);

`ifdef FRACTRAN_STEP_LIMIT_EN
    assign limit_hit = limit_q;
`else
    assign limit_hit = 1'b0;
    logic unused_limit;
    assign unused_limit = limit_q ^ (^MAX_STEPS);
`endif

endmodule
